// File: rtl/ddr_local_ram.sv
// RAM-backed responder for the DDR controller local burst interface, modelling init, ready and read latency.
// Optional periodic refresh stalls are enabled by defining DDR_LOCAL_RAM_REFRESH_EN.
module ddr_local_ram #(
    parameter int LOCAL_AW       = 23,
    parameter int MEM_AW         = 14,
    parameter int INIT_CYCLES    = 16,
    parameter int READ_LATENCY   = 4,
    parameter int REFRESH_PERIOD = 780,
    parameter int REFRESH_CYCLES = 8
) (
    input  logic                wb_clk,
    input  logic                wb_rst,
    input  logic [LOCAL_AW-1:0] local_address,
    input  logic                local_write_req,
    input  logic                local_read_req,
    input  logic                local_burstbegin,
    input  logic [31:0]         local_wdata,
    input  logic [3:0]          local_be,
    input  logic [6:0]          local_size,
    output logic                local_ready,
    output logic [31:0]         local_rdata,
    output logic                local_rdata_valid,
    output logic                local_init_done,
    output logic                local_reset_n
);

`ifdef DDR_LOCAL_RAM_REFRESH_EN
    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_WRITE, ST_READ, ST_REFRESH} state_t;
    logic [15:0] ref_cnt;
    logic [7:0]  ref_len;
    logic        refresh_pending;
`else
    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_WRITE, ST_READ} state_t;
    localparam int unused_refresh = REFRESH_PERIOD + REFRESH_CYCLES;
`endif

    state_t state, next_state;

    logic [31:0]       mem [0:(1<<MEM_AW)-1];
    logic [7:0]        init_cnt;
    logic [MEM_AW-1:0] base;
    logic [6:0]        size_q;
    logic [6:0]        beat_cnt;
    logic [3:0]        lat_cnt;
    logic [6:0]        eff_size;
    logic              wr_en;
    logic              wr_start;
    logic              rd_start;
    logic              rd_emit;
    logic [MEM_AW-1:0] wr_idx;
    logic [MEM_AW-1:0] rd_idx;
    logic              unused_addr;

    assign unused_addr = ^local_address[LOCAL_AW-1:MEM_AW];
    assign eff_size    = (local_size == 7'd0) ? 7'd1 : local_size;
    assign rd_idx      = base + MEM_AW'(beat_cnt);

    always_ff @(posedge wb_clk) begin
        if (wb_rst)
            state <= ST_INIT;
        else
            state <= next_state;
    end

    // Writes win over reads when both are requested at a burst start.
    always_comb begin
        next_state  = state;
        local_ready = 1'b0;
        wr_en       = 1'b0;
        wr_start    = 1'b0;
        rd_start    = 1'b0;
        rd_emit     = 1'b0;
        wr_idx      = local_address[MEM_AW-1:0];
        case (state)
            ST_INIT: begin
                if (init_cnt == 8'(INIT_CYCLES))
                    next_state = ST_IDLE;
            end
            ST_IDLE: begin
                local_ready = 1'b1;
                if (local_write_req && local_burstbegin) begin
                    wr_en    = 1'b1;
                    wr_start = 1'b1;
                    if (eff_size > 7'd1)
                        next_state = ST_WRITE;
                end else if (local_read_req && local_burstbegin) begin
                    rd_start   = 1'b1;
                    next_state = ST_READ;
                end
`ifdef DDR_LOCAL_RAM_REFRESH_EN
                else if (refresh_pending) begin
                    next_state = ST_REFRESH;
                end
`endif
            end
            ST_WRITE: begin
                local_ready = 1'b1;
                wr_idx      = base + MEM_AW'(beat_cnt);
                if (local_write_req) begin
                    wr_en = 1'b1;
                    if (beat_cnt == size_q - 7'd1)
                        next_state = ST_IDLE;
                end
            end
            ST_READ: begin
                if (lat_cnt == 4'(READ_LATENCY)) begin
                    if (beat_cnt == size_q)
                        next_state = ST_IDLE;
                    else
                        rd_emit = 1'b1;
                end
            end
`ifdef DDR_LOCAL_RAM_REFRESH_EN
            ST_REFRESH: begin
                if (ref_len == 8'(REFRESH_CYCLES - 1))
                    next_state = ST_IDLE;
            end
`endif
            default: next_state = ST_INIT;
        endcase
    end

    // Memory has no reset so contents survive a controller reset.
    always_ff @(posedge wb_clk) begin
        if (wr_en && !wb_rst) begin
            for (int b = 0; b < 4; b++) begin
                if (local_be[b])
                    mem[wr_idx][8*b +: 8] <= local_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            init_cnt          <= 8'd0;
            local_init_done   <= 1'b0;
            local_reset_n     <= 1'b0;
            local_rdata_valid <= 1'b0;
            local_rdata       <= 32'd0;
            base              <= '0;
            size_q            <= 7'd0;
            beat_cnt          <= 7'd0;
            lat_cnt           <= 4'd0;
`ifdef DDR_LOCAL_RAM_REFRESH_EN
            ref_cnt           <= 16'd0;
            ref_len           <= 8'd0;
            refresh_pending   <= 1'b0;
`endif
        end else begin
            local_reset_n     <= 1'b1;
            local_rdata_valid <= rd_emit;
            if (state == ST_INIT) begin
                if (init_cnt == 8'(INIT_CYCLES))
                    local_init_done <= 1'b1;
                else
                    init_cnt <= init_cnt + 8'd1;
            end
            if (wr_start) begin
                base     <= local_address[MEM_AW-1:0];
                size_q   <= eff_size;
                beat_cnt <= 7'd1;
            end else if (wr_en) begin
                beat_cnt <= beat_cnt + 7'd1;
            end
            if (rd_start) begin
                base     <= local_address[MEM_AW-1:0];
                size_q   <= eff_size;
                beat_cnt <= 7'd0;
                lat_cnt  <= 4'd1;
            end else if (state == ST_READ && lat_cnt != 4'(READ_LATENCY)) begin
                lat_cnt <= lat_cnt + 4'd1;
            end
            if (rd_emit) begin
                local_rdata <= mem[rd_idx];
                beat_cnt    <= beat_cnt + 7'd1;
            end
`ifdef DDR_LOCAL_RAM_REFRESH_EN
            // A refresh that falls due during a refresh is absorbed by the clear at its end.
            if (local_init_done) begin
                if (ref_cnt == 16'(REFRESH_PERIOD - 1)) begin
                    ref_cnt         <= 16'd0;
                    refresh_pending <= 1'b1;
                end else begin
                    ref_cnt <= ref_cnt + 16'd1;
                end
            end
            if (state == ST_REFRESH) begin
                if (ref_len == 8'(REFRESH_CYCLES - 1)) begin
                    ref_len         <= 8'd0;
                    refresh_pending <= 1'b0;
                end else begin
                    ref_len <= ref_len + 8'd1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_ddr_local_ram.sv
// Self-checking bench for ddr_local_ram: directed bursts, a reference memory model
// and a read-data scoreboard checked whenever local_rdata_valid is high.
module tb_ddr_local_ram;

    localparam int LOCAL_AW     = 23;
    localparam int MEM_AW       = 14;
    localparam int INIT_CYCLES  = 16;
    localparam int READ_LATENCY = 4;
    localparam int DEPTH        = 1 << MEM_AW;

    logic                wb_clk = 1'b0;
    logic                wb_rst = 1'b1;
    logic [LOCAL_AW-1:0] local_address = '0;
    logic                local_write_req = 1'b0;
    logic                local_read_req = 1'b0;
    logic                local_burstbegin = 1'b0;
    logic [31:0]         local_wdata = 32'd0;
    logic [3:0]          local_be = 4'd0;
    logic [6:0]          local_size = 7'd0;
    logic                local_ready;
    logic [31:0]         local_rdata;
    logic                local_rdata_valid;
    logic                local_init_done;
    logic                local_reset_n;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] exp_q [$];
    logic [31:0] model [int];

    always #5 wb_clk = ~wb_clk;

    ddr_local_ram #(
        .LOCAL_AW(LOCAL_AW),
        .MEM_AW(MEM_AW),
        .INIT_CYCLES(INIT_CYCLES),
        .READ_LATENCY(READ_LATENCY),
        .REFRESH_PERIOD(780),
        .REFRESH_CYCLES(8)
    ) dut (
        .wb_clk(wb_clk),
        .wb_rst(wb_rst),
        .local_address(local_address),
        .local_write_req(local_write_req),
        .local_read_req(local_read_req),
        .local_burstbegin(local_burstbegin),
        .local_wdata(local_wdata),
        .local_be(local_be),
        .local_size(local_size),
        .local_ready(local_ready),
        .local_rdata(local_rdata),
        .local_rdata_valid(local_rdata_valid),
        .local_init_done(local_init_done),
        .local_reset_n(local_reset_n)
    );

    task automatic step();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic rd, input logic bb,
                                 input logic [LOCAL_AW-1:0] addr, input logic [6:0] size,
                                 input logic [31:0] wdata, input logic [3:0] be);
        local_write_req  = wr;
        local_read_req   = rd;
        local_burstbegin = bb;
        local_address    = addr;
        local_size       = size;
        local_wdata      = wdata;
        local_be         = be;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 7'd0, 32'd0, 4'd0);
    endtask

    function automatic logic [31:0] modelRead(input int idx);
        return model.exists(idx) ? model[idx] : 32'h0;
    endfunction

    task automatic modelWrite(input int idx, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] word;
        word = modelRead(idx);
        for (int b = 0; b < 4; b++)
            if (be[b]) word[8*b +: 8] = d[8*b +: 8];
        model[idx] = word;
    endtask

    task automatic writeBurst(input int addr, input int n, input logic [31:0] d0, input logic [3:0] be);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, (i == 0), LOCAL_AW'(addr), 7'(n), d0 + 32'(i), be);
            modelWrite((addr + i) % DEPTH, d0 + 32'(i), be);
            step();
        end
        idleInputs();
    endtask

    // Checks the exact valid window relative to the accept edge; data goes through the scoreboard.
    task automatic readBurst(input int addr, input int size, input string tag);
        int n;
        logic [31:0] last;
        n = (size == 0) ? 1 : size;
        last = 32'd0;
        checkOutput({tag, "_ready_before"}, 32'(local_ready), 32'd1);
        for (int i = 0; i < n; i++) begin
            last = modelRead((addr + i) % DEPTH);
            exp_q.push_back(last);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, LOCAL_AW'(addr), 7'(size), 32'd0, 4'd0);
        step();
        idleInputs();
        for (int c = 0; c <= READ_LATENCY + n; c++) begin
            if (c > 0) step();
            checkOutput({tag, "_valid"}, 32'(local_rdata_valid),
                        32'((c >= READ_LATENCY) && (c < READ_LATENCY + n)));
        end
        checkOutput({tag, "_ready_after"}, 32'(local_ready), 32'd1);
        checkOutput({tag, "_rdata_hold"}, local_rdata, last);
        checkOutput({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    always @(posedge wb_clk) begin
        #1;
        if (local_rdata_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $error("[TB] FAIL rdata_unexpected: observed %h expected no valid beat", local_rdata);
            end else begin
                checkOutput("rdata", local_rdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        // Reset values and init timing
        repeat (3) step();
        checkOutput("rst_ready", 32'(local_ready), 32'd0);
        checkOutput("rst_valid", 32'(local_rdata_valid), 32'd0);
        checkOutput("rst_rdata", local_rdata, 32'd0);
        checkOutput("rst_init_done", 32'(local_init_done), 32'd0);
        checkOutput("rst_reset_n", 32'(local_reset_n), 32'd0);
        wb_rst = 1'b0;
        step();
        checkOutput("reset_n_rise", 32'(local_reset_n), 32'd1);
        checkOutput("init_done_early", 32'(local_init_done), 32'd0);
        for (int c = 1; c <= INIT_CYCLES; c++) begin
            step();
            checkOutput("init_done", 32'(local_init_done), 32'(c == INIT_CYCLES));
            checkOutput("init_ready", 32'(local_ready), 32'(c == INIT_CYCLES));
            checkOutput("init_valid", 32'(local_rdata_valid), 32'd0);
        end

        // Burst write then read back
        writeBurst(32'h100, 4, 32'hA0, 4'hF);
        readBurst(32'h100, 4, "burst4");

        // Byte enables
        writeBurst(32'h20, 1, 32'hFFFF_FFFF, 4'hF);
        writeBurst(32'h20, 1, 32'h1234_5678, 4'h5);
        readBurst(32'h20, 1, "byte_en");

        // Write request without burstbegin in IDLE is ignored
        applyStimulus(1'b1, 1'b0, 1'b0, LOCAL_AW'(32'h20), 7'd1, 32'h0, 4'hF);
        step();
        idleInputs();
        readBurst(32'h20, 1, "no_burstbegin");

        // Address wrap, high address bits, size 0
        writeBurst(DEPTH - 1, 3, 32'd1, 4'hF);
        readBurst(DEPTH - 1, 3, "wrap");
        readBurst(DEPTH, 1, "high_addr");
        readBurst(1, 0, "size0");

        // Simultaneous write and read: only the write happens
        applyStimulus(1'b1, 1'b1, 1'b1, LOCAL_AW'(32'h50), 7'd1, 32'hCAFE_0001, 4'hF);
        modelWrite(32'h50, 32'hCAFE_0001, 4'hF);
        step();
        idleInputs();
        for (int c = 0; c < 8; c++) begin
            step();
            checkOutput("collide_valid", 32'(local_rdata_valid), 32'd0);
        end
        checkOutput("collide_ready", 32'(local_ready), 32'd1);
        readBurst(32'h50, 1, "collide");

        // Reset during the second beat of a size-8 read
        writeBurst(32'h200, 8, 32'h0000_0200, 4'hF);
        exp_q.push_back(modelRead(32'h200));
        exp_q.push_back(modelRead(32'h201));
        applyStimulus(1'b0, 1'b1, 1'b1, LOCAL_AW'(32'h200), 7'd8, 32'd0, 4'd0);
        step();
        idleInputs();
        repeat (READ_LATENCY + 1) step();
        checkOutput("mid_read_valid", 32'(local_rdata_valid), 32'd1);
        wb_rst = 1'b1;
        step();
        checkOutput("mid_rst_valid", 32'(local_rdata_valid), 32'd0);
        checkOutput("mid_rst_ready", 32'(local_ready), 32'd0);
        checkOutput("mid_rst_rdata", local_rdata, 32'd0);
        checkOutput("mid_rst_init_done", 32'(local_init_done), 32'd0);
        checkOutput("mid_rst_reset_n", 32'(local_reset_n), 32'd0);
        checkOutput("mid_rst_beats_seen", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        wb_rst = 1'b0;
        step();
        checkOutput("reinit_reset_n", 32'(local_reset_n), 32'd1);
        repeat (INIT_CYCLES - 1) step();
        checkOutput("reinit_not_done", 32'(local_init_done), 32'd0);
        step();
        checkOutput("reinit_done", 32'(local_init_done), 32'd1);
        checkOutput("reinit_ready", 32'(local_ready), 32'd1);
        readBurst(32'h200, 8, "post_reset");

        repeat (4) step();
        checkOutput("final_queue", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
